// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampled UART receiver with rdsig/rd_ack handshake
//
// Purpose: receives one UART frame at a time from the rx pin. The frame has a start bit,
// DATA_BITS data bits sent LSB first, an optional parity bit and STOP_BITS stop bits.
// Each finished word is held in dataout together with its error flags until the consumer
// accepts it with rd_ack.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active high
//   rx          serial input, asynchronous to clk
//   dataout     received word, valid while rdsig=1
//   rdsig       word available, held until accepted by rd_ack
//   rd_ack      consumer accepts the word in any cycle where rdsig=1
//   dataerror   parity error for the word in dataout
//   frameerror  a stop bit was sampled 0 for the word in dataout
//   breakdet    the word in dataout was a break (every sampled bit was 0)
//   overrun     sticky: an unaccepted word was overwritten
//   busy        frame reception in progress
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 rdsig,
    output logic                 dataerror,
    output logic                 frameerror,
    output logic                 breakdet,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // The start bit is sampled one cycle earlier than a plain half-bit count would give,
    // because entering START already costs a cycle after the edge is seen. Every later
    // sample then lands exactly one bit time after the previous one, and the last stop
    // sample loads the outputs directly, so rdsig rises in the cycle after it.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic                 rx_prev_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q;
    logic                 stop_err_q;
    logic                 seen_one_q;
    logic [DATA_BITS-1:0] dataout_q;
    logic                 rdsig_q;
    logic                 dataerror_q;
    logic                 frameerror_q;
    logic                 breakdet_q;
    logic                 overrun_q;
    logic                 busy_q;

    logic bit_tick;
    logic accept;
    logic par_err_d;

    assign bit_tick = (cnt_q == BIT_LAST);
    assign accept   = rdsig_q & rd_ack;

    always_comb begin
        par_err_d = 1'b0;
        if (PARITY == 1) begin
            par_err_d = par_bit_q ^ (^shift_q);
        end else if (PARITY == 2) begin
            par_err_d = par_bit_q ^ ~(^shift_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            seen_one_q   <= 1'b0;
            dataout_q    <= '0;
            rdsig_q      <= 1'b0;
            dataerror_q  <= 1'b0;
            frameerror_q <= 1'b0;
            breakdet_q   <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            cnt_q     <= cnt_q + CNT_W'(1);

            if (accept) begin
                rdsig_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_s_q && rx_prev_q) begin
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                        stop_err_q <= 1'b0;
                        seen_one_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == START_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            // Line went back high before mid start bit: a glitch, not a frame.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt_q      <= '0;
                        shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                        seen_one_q <= seen_one_q | rx_s_q;
                        if (idx_q == DATA_LAST) begin
                            idx_q   <= '0;
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_tick) begin
                        cnt_q      <= '0;
                        par_bit_q  <= rx_s_q;
                        seen_one_q <= seen_one_q | rx_s_q;
                        state_q    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            stop_err_q <= 1'b1;
                        end
                        seen_one_q <= seen_one_q | rx_s_q;
                        if (idx_q == STOP_LAST) begin
                            idx_q        <= '0;
                            busy_q       <= 1'b0;
                            dataout_q    <= shift_q;
                            dataerror_q  <= par_err_d;
                            frameerror_q <= stop_err_q | ~rx_s_q;
                            breakdet_q   <= ~(seen_one_q | rx_s_q);
                            rdsig_q      <= 1'b1;
                            // Overwriting a word nobody took is an overrun; an accept in
                            // this same cycle means the old word was consumed in time.
                            overrun_q    <= rdsig_q & ~rd_ack;
                            state_q      <= rx_s_q ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // A line stuck low (break) must return high before a new start edge counts.
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dataout    = dataout_q;
    assign rdsig      = rdsig_q;
    assign dataerror  = dataerror_q;
    assign frameerror = frameerror_q;
    assign breakdet   = breakdet_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rd_ack_a = 1'b0;
    logic [7:0] dataout_a;
    logic       rdsig_a, dataerror_a, frameerror_a, breakdet_a, overrun_a, busy_a;

    logic       rx_b = 1'b1;
    logic       rd_ack_b = 1'b0;
    logic [6:0] dataout_b;
    logic       rdsig_b, dataerror_b, frameerror_b, breakdet_b, overrun_b, busy_b;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_a   = 0;
    int fall_b   = 0;
    int rise_a   = -1;
    int rise_b   = -1;
    logic rdsig_a_prev = 1'b0;
    logic rdsig_b_prev = 1'b0;
    logic busy_seen_a  = 1'b0;

    uart_rx_param uut_a (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_a),
        .rd_ack     (rd_ack_a),
        .dataout    (dataout_a),
        .rdsig      (rdsig_a),
        .dataerror  (dataerror_a),
        .frameerror (frameerror_a),
        .breakdet   (breakdet_a),
        .overrun    (overrun_a),
        .busy       (busy_a)
    );

    uart_rx_param #(
        .CLKS_PER_BIT (16),
        .DATA_BITS    (7),
        .PARITY       (0),
        .STOP_BITS    (2)
    ) uut_b (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx_b),
        .rd_ack     (rd_ack_b),
        .dataout    (dataout_b),
        .rdsig      (rdsig_b),
        .dataerror  (dataerror_b),
        .frameerror (frameerror_b),
        .breakdet   (breakdet_b),
        .overrun    (overrun_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdsig_a && !rdsig_a_prev) rise_a = cyc;
        if (rdsig_b && !rdsig_b_prev) rise_b = cyc;
        rdsig_a_prev = rdsig_a;
        rdsig_b_prev = rdsig_b;
        if (busy_a) busy_seen_a = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All stimulus starts 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_a(input logic v);
        rx_a = v;
        step(16);
    endtask

    task automatic bit_b(input logic v);
        rx_b = v;
        step(16);
    endtask

    task automatic send_a(input logic [7:0] d, input logic p, input logic s);
        fall_a = cyc;
        bit_a(1'b0);
        for (int i = 0; i < 8; i++) bit_a(d[i]);
        bit_a(p);
        bit_a(s);
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [6:0] d, input logic s1, input logic s2);
        fall_b = cyc;
        bit_b(1'b0);
        for (int i = 0; i < 7; i++) bit_b(d[i]);
        bit_b(s1);
        bit_b(s2);
        rx_b = 1'b1;
    endtask

    task automatic ack_a();
        rd_ack_a = 1'b1;
        step(1);
        rd_ack_a = 1'b0;
    endtask

    task automatic ack_b();
        rd_ack_b = 1'b1;
        step(1);
        rd_ack_b = 1'b0;
    endtask

    initial begin
        // Reset state
        step(3);
        chk("rst_rdsig",   {31'd0, rdsig_a},   32'd0);
        chk("rst_dataout", {24'd0, dataout_a}, 32'd0);
        chk("rst_flags",   {28'd0, dataerror_a, frameerror_a, breakdet_a, overrun_a}, 32'd0);
        chk("rst_busy",    {31'd0, busy_a},    32'd0);
        chk("rst_b_all",   {22'd0, dataout_b, rdsig_b, busy_b, overrun_b}, 32'd0);
        rst = 1'b0;
        step(5);

        // 1: 0xA5, even parity bit 0, good stop
        send_a(8'hA5, 1'b0, 1'b1);
        step(2);
        chk("t1_latency",  rise_a - fall_a, 32'd170);
        chk("t1_rdsig",    {31'd0, rdsig_a},   32'd1);
        chk("t1_dataout",  {24'd0, dataout_a}, 32'h0A5);
        chk("t1_flags",    {28'd0, dataerror_a, frameerror_a, breakdet_a, overrun_a}, 32'd0);
        chk("t1_busy",     {31'd0, busy_a},    32'd0);
        ack_a();
        chk("t1_ack",      {31'd0, rdsig_a},   32'd0);
        step(3);
        chk("t1_hold",     {24'd0, dataout_a}, 32'h0A5);

        // 2: 0x01 with parity bit 0 (even parity needs 1)
        send_a(8'h01, 1'b0, 1'b1);
        step(2);
        chk("t2_dataout",  {24'd0, dataout_a}, 32'h001);
        chk("t2_perr",     {31'd0, dataerror_a},  32'd1);
        chk("t2_ferr",     {31'd0, frameerror_a}, 32'd0);
        ack_a();
        chk("t2_ack",      {31'd0, rdsig_a},   32'd0);
        chk("t2_perr_hold", {31'd0, dataerror_a}, 32'd1);

        // 3a: 0x3C with stop bit 0
        send_a(8'h3C, 1'b0, 1'b0);
        step(20);
        chk("t3_dataout",  {24'd0, dataout_a}, 32'h03C);
        chk("t3_flags",    {28'd0, dataerror_a, frameerror_a, breakdet_a, overrun_a}, 32'b0100);
        ack_a();

        // 3b: break, line held low for 12 bit times
        fall_a = cyc;
        rx_a = 1'b0;
        step(192);
        chk("t3_brk_lat",  rise_a - fall_a, 32'd170);
        chk("t3_brk_rdsig", {31'd0, rdsig_a},  32'd1);
        chk("t3_brk_data", {24'd0, dataout_a}, 32'd0);
        chk("t3_brk_flags", {28'd0, dataerror_a, frameerror_a, breakdet_a, overrun_a}, 32'b0110);
        ack_a();
        step(200);
        chk("t3_wait_rdsig", {31'd0, rdsig_a}, 32'd0);
        chk("t3_wait_busy",  {31'd0, busy_a},  32'd0);
        rx_a = 1'b1;
        step(20);

        // 4: 5-clock glitch is a false start
        busy_seen_a = 1'b0;
        rx_a = 1'b0;
        step(5);
        rx_a = 1'b1;
        step(40);
        chk("t4_busy_pulse", {31'd0, busy_seen_a}, 32'd1);
        chk("t4_busy_end",   {31'd0, busy_a},      32'd0);
        chk("t4_rdsig",      {31'd0, rdsig_a},     32'd0);
        chk("t4_flags",    {28'd0, dataerror_a, frameerror_a, breakdet_a, overrun_a}, 32'b0110);
        chk("t4_dataout",  {24'd0, dataout_a}, 32'd0);

        // 5: two words back-to-back, no ack -> overrun
        send_a(8'h11, 1'b0, 1'b1);
        chk("t5_first",    {24'd0, dataout_a}, 32'h011);
        chk("t5_first_ovr", {31'd0, overrun_a}, 32'd0);
        send_a(8'h22, 1'b0, 1'b1);
        step(2);
        chk("t5_dataout",  {24'd0, dataout_a}, 32'h022);
        chk("t5_rdsig",    {31'd0, rdsig_a},   32'd1);
        chk("t5_overrun",  {31'd0, overrun_a}, 32'd1);
        chk("t5_errs",     {29'd0, dataerror_a, frameerror_a, breakdet_a}, 32'd0);
        ack_a();
        chk("t5_ack_rdsig", {31'd0, rdsig_a},   32'd0);
        chk("t5_ack_ovr",   {31'd0, overrun_a}, 32'd0);

        // 5b: word completes in the same cycle as an accepting rd_ack
        send_a(8'h33, 1'b0, 1'b1);
        fork
            send_a(8'h44, 1'b1, 1'b1);
            begin
                repeat (169) @(posedge clk);
                #1 rd_ack_a = 1'b1;
                @(posedge clk);
                #1 rd_ack_a = 1'b0;
            end
        join
        step(2);
        chk("t5b_dataout", {24'd0, dataout_a}, 32'h044);
        chk("t5b_rdsig",   {31'd0, rdsig_a},   32'd1);
        chk("t5b_overrun", {31'd0, overrun_a}, 32'd0);
        ack_a();

        // 6: 7 data bits, no parity, 2 stop bits
        send_b(7'h55, 1'b1, 1'b1);
        step(2);
        chk("t6_latency",  rise_b - fall_b, 32'd154);
        chk("t6_dataout",  {25'd0, dataout_b}, 32'h055);
        chk("t6_flags",    {28'd0, dataerror_b, frameerror_b, breakdet_b, overrun_b}, 32'd0);
        ack_b();
        send_b(7'h55, 1'b1, 1'b0);
        step(2);
        chk("t6_stop2_ferr", {31'd0, frameerror_b}, 32'd1);
        chk("t6_stop2_data", {25'd0, dataout_b},    32'h055);
        ack_b();

        // Reset asserted mid-frame, held until the line is idle again
        fork
            send_b(7'h2A, 1'b1, 1'b1);
            begin
                step(80);
                rst = 1'b1;
            end
        join
        step(1);
        chk("t6_rst_b",  {22'd0, dataout_b, rdsig_b, busy_b, frameerror_b}, 32'd0);
        chk("t6_rst_a",  {24'd0, dataout_a}, 32'd0);
        rst = 1'b0;
        step(20);
        chk("t6_abandon", {31'd0, rdsig_b}, 32'd0);
        send_b(7'h2A, 1'b1, 1'b1);
        step(2);
        chk("t6_post_lat",  rise_b - fall_b, 32'd154);
        chk("t6_post_data", {25'd0, dataout_b}, 32'h02A);
        chk("t6_post_flags", {28'd0, dataerror_b, frameerror_b, breakdet_b, overrun_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
